// File: rtl/nonce_search_ctrl.sv
// Purpose: walks a 32-bit nonce range through an external hash core and target checker, stops on the first match or at range end.
// Latency: 4 cycles per nonce plus hash core latency (LAUNCH, WAIT_HASH>=1, CHK_EN, CHK_RES), then one FINISH cycle with done.
// Backpressure: waits indefinitely in WAIT_HASH for hash_done; abort exits to IDLE next cycle. Optional macro NONCE_SEARCH_CONTINUE_EN keeps searching after a match.
module nonce_search_ctrl (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         abort,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_end,
  output logic         hash_start,
  output logic [31:0]  hash_nonce,
  input  logic         hash_done,
  input  logic [255:0] hash_value,
  output logic         chk_enable,
  output logic [255:0] chk_hash,
  input  logic         chk_valid,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic         exhausted,
  output logic [31:0]  found_nonce,
  output logic [255:0] found_hash,
  output logic [32:0]  nonces_tried
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_HASH = 3'd2,
    CHK_EN    = 3'd3,
    CHK_RES   = 3'd4,
    FINISH    = 3'd5
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] cur_nonce;
  logic [31:0] end_reg;
  logic        last_nonce;
  logic        stop_on_match;

  assign last_nonce = (cur_nonce == end_reg);
  assign busy       = (state != IDLE);
  assign hash_nonce = cur_nonce;

`ifdef NONCE_SEARCH_CONTINUE_EN
  // A match never ends the search; only the end of the range or abort does.
  assign stop_on_match = 1'b0;
`else
  assign stop_on_match = chk_valid;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and strobes; abort suppresses any strobe in the cycle it is seen.
  always_comb begin
    state_nxt  = state;
    hash_start = 1'b0;
    chk_enable = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        hash_start = !abort;
        state_nxt  = WAIT_HASH;
      end
      WAIT_HASH: begin
        if (hash_done) begin
          state_nxt = CHK_EN;
        end
      end
      CHK_EN: begin
        chk_enable = !abort;
        state_nxt  = CHK_RES;
      end
      CHK_RES: begin
        if (stop_on_match || last_nonce) begin
          state_nxt = FINISH;
        end else begin
          state_nxt = LAUNCH;
        end
      end
      FINISH: begin
        done      = !abort;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (abort && (state != IDLE)) begin
      state_nxt = IDLE;
    end
  end

  // Datapath: range registers, captured digest, result flags and nonce counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_nonce    <= 32'd0;
      end_reg      <= 32'd0;
      chk_hash     <= 256'd0;
      found        <= 1'b0;
      exhausted    <= 1'b0;
      found_nonce  <= 32'd0;
      found_hash   <= 256'd0;
      nonces_tried <= 33'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            cur_nonce    <= nonce_start;
            end_reg      <= nonce_end;
            found        <= 1'b0;
            exhausted    <= 1'b0;
            nonces_tried <= 33'd0;
          end
        end
        WAIT_HASH: begin
          if (hash_done && !abort) begin
            chk_hash <= hash_value;
          end
        end
        CHK_RES: begin
          if (!abort) begin
            nonces_tried <= nonces_tried + 33'd1;
            if (chk_valid) begin
              found       <= 1'b1;
              found_nonce <= cur_nonce;
              found_hash  <= chk_hash;
            end
            if (!stop_on_match) begin
              if (last_nonce) begin
                exhausted <= 1'b1;
              end else begin
                cur_nonce <= cur_nonce + 32'd1;
              end
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/nonce_search_ctrl.md
NONCE_SEARCH_CTRL -- requirements
Module: nonce_search_ctrl

Interface
REQ-001 SHALL have no parameters; nonce width fixed at 32 bits, hash width fixed at 256 bits.
REQ-002 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have: reset_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have: start  in  1  one-cycle request to begin a search; honoured in IDLE only.
REQ-005 SHALL have: abort  in  1  terminate search immediately.
REQ-006 SHALL have: nonce_start  in  32  first nonce; nonce_end  in  32  last nonce, inclusive; both sampled on accepted start.
REQ-007 SHALL have: hash_start  out  1  one-cycle launch pulse to hash core; hash_nonce  out  32  nonce under test, valid while hash_start=1.
REQ-008 SHALL have: hash_done  in  1  hash core result strobe; hash_value  in  256  digest, valid while hash_done=1.
REQ-009 SHALL have: chk_enable  out  1  enable to target checker; chk_hash  out  256  registered digest driven to checker; chk_valid  in  1  checker result, registered, one cycle after chk_enable.
REQ-010 SHALL have: busy  out  1  search active; done  out  1  one-cycle completion pulse; found  out  1  match flag; exhausted  out  1  range finished without match.
REQ-011 SHALL have: found_nonce  out  32  matching nonce; found_hash  out  256  matching digest; nonces_tried  out  33  nonces checked in current/last search.

Function
REQ-012 SHALL implement FSM states IDLE, LAUNCH, WAIT_HASH, CHK_EN, CHK_RES, FINISH.
REQ-013 IDLE: start=1 and abort=0 SHALL latch cur_nonce<=nonce_start, end_reg<=nonce_end; clear found, exhausted, nonces_tried; go LAUNCH.
REQ-014 LAUNCH: hash_start=1 for exactly one cycle with hash_nonce=cur_nonce; go WAIT_HASH.
REQ-015 WAIT_HASH: stay until hash_done=1; then chk_hash<=hash_value; go CHK_EN. hash_done outside WAIT_HASH SHALL be ignored.
REQ-016 CHK_EN: chk_enable=1 for exactly one cycle; go CHK_RES.
REQ-017 CHK_RES: nonces_tried increments by 1; if chk_valid=1 then found<=1, found_nonce<=cur_nonce, found_hash<=chk_hash, go FINISH; else if cur_nonce==end_reg then exhausted<=1, go FINISH; else cur_nonce<=cur_nonce+1 (mod 2^32), go LAUNCH.
REQ-018 FINISH: done=1 for one cycle; go IDLE.
REQ-019 Per-nonce latency: 4 cycles plus hash core latency (LAUNCH, WAIT_HASH≥1, CHK_EN, CHK_RES).
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 nonce_end < nonce_start SHALL wrap through 0xFFFFFFFF to 0x00000000; nonce_start==nonce_end SHALL test exactly one nonce.
REQ-022 Range 0x00000000..0xFFFFFFFF SHALL test 2^32 nonces; nonces_tried reaches 0x1_0000_0000 without overflow.
REQ-023 abort=1 in any non-IDLE state SHALL force IDLE next cycle with no done pulse, found and exhausted left 0, no further hash_start or chk_enable.
REQ-024 abort=1 with start=1 in IDLE: abort wins, start ignored.
REQ-025 start while busy SHALL be ignored.
REQ-026 found, exhausted, found_nonce, found_hash, nonces_tried SHALL hold after FINISH until next accepted start.

Reset
REQ-027 reset_n=0 SHALL asynchronously force IDLE and clear all outputs and registers to 0, including mid-search; hash_done arriving after reset release is ignored.

Configuration
REQ-028 Macro NONCE_SEARCH_CONTINUE_EN defined: a match SHALL update found_nonce/found_hash, set found, and continue to next nonce; search ends only at end_reg (exhausted<=1 regardless of found) or abort; found_nonce holds the last match.
REQ-029 Macro undefined: search SHALL stop at first match per REQ-017.

Verification
REQ-030 start, range 0x10..0x13, chk_valid=1 only for nonce 0x12 -> hash_nonce 0x10,0x11,0x12; found=1, found_nonce=0x12, nonces_tried=3, one done pulse; with NONCE_SEARCH_CONTINUE_EN -> 0x13 also tested, nonces_tried=4, exhausted=1.
REQ-031 Range 0xFFFFFFFE..0x00000001, no match -> nonces 0xFFFFFFFE,0xFFFFFFFF,0x0,0x1 tested; exhausted=1, found=0, nonces_tried=4.
REQ-032 Range 0x5..0x5, no match -> one hash_start, exhausted=1, done pulse 4 cycles after hash_done-free latency with 1-cycle hash core.
REQ-033 abort asserted in WAIT_HASH of 2nd nonce -> IDLE next cycle, no done, late hash_done ignored, no chk_enable.
REQ-034 reset_n low during CHK_EN -> all outputs 0 immediately; start after release runs normally from nonce_start.
REQ-035 start pulsed while busy and start+abort together in IDLE -> both ignored, nonce sequence and busy unchanged.
